// File: rtl/ram_writeback_controller.sv
// ram_writeback_controller: buffers store requests from the execute stage in a
// small FIFO and replays them as single-cycle writes to program RAM (poke) or
// variable RAM (store), or as multi-cycle replicated-value bursts (fill).
// All RAM-side outputs are registered; req_ready and busy are combinational.
module ram_writeback_controller #(
    parameter int WORD_SIZE        = 16,
    parameter int ADDR_SIZE        = 8,
    parameter int MODE_SELECT_SIZE = 3,
    parameter int COUNT_SIZE       = 8,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [MODE_SELECT_SIZE-1:0] req_mode,
    input  logic [ADDR_SIZE-1:0]        req_addr,
    input  logic [WORD_SIZE-1:0]        req_data,
    input  logic [COUNT_SIZE-1:0]       req_count,
    output logic                        p_ram_we,
    output logic [ADDR_SIZE-1:0]        p_ram_addr,
    output logic [WORD_SIZE-1:0]        p_ram_wdata,
    output logic                        v_ram_we,
    output logic [ADDR_SIZE-1:0]        v_ram_addr,
    output logic [WORD_SIZE-1:0]        v_ram_wdata,
    output logic                        busy,
    output logic                        err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [MODE_SELECT_SIZE-1:0] MODE_POKE  = MODE_SELECT_SIZE'(1);
    localparam logic [MODE_SELECT_SIZE-1:0] MODE_STORE = MODE_SELECT_SIZE'(2);
    localparam logic [MODE_SELECT_SIZE-1:0] MODE_FILL  = MODE_SELECT_SIZE'(3);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state;

    logic [MODE_SELECT_SIZE-1:0] fifo_mode  [FIFO_DEPTH];
    logic [ADDR_SIZE-1:0]        fifo_addr  [FIFO_DEPTH];
    logic [WORD_SIZE-1:0]        fifo_data  [FIFO_DEPTH];
    logic [COUNT_SIZE-1:0]       fifo_count [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic [COUNT_SIZE-1:0] remain;

    logic push;
    logic pop;

    logic [MODE_SELECT_SIZE-1:0] head_mode;
    logic [ADDR_SIZE-1:0]        head_addr;
    logic [WORD_SIZE-1:0]        head_data;
    logic [COUNT_SIZE-1:0]       head_count;

    // Ready depends only on occupancy, so a pop on the same edge never lets a
    // push into a full FIFO.
    assign req_ready = (occ != FULL_OCC);
    assign push      = req_valid && req_ready;

    // The head is consumed whenever the sequencer is free: in IDLE, or on the
    // final beat of a fill so the next write follows without a bubble.
    assign pop = (occ != '0) && !(state == FILL && remain != '0);

    assign head_mode  = fifo_mode[rd_ptr];
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    assign head_count = fifo_count[rd_ptr];

    assign busy = (occ != '0) || (state == FILL) || p_ram_we || v_ram_we;

    // Request storage: payload only, no reset needed since occupancy guards it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mode[wr_ptr]  <= req_mode;
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_data[wr_ptr]  <= req_data;
            fifo_count[wr_ptr] <= req_count;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Write sequencer: decodes the popped head into at most one registered
    // RAM write per cycle and steps through fill bursts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            remain      <= '0;
            p_ram_we    <= 1'b0;
            p_ram_addr  <= '0;
            p_ram_wdata <= '0;
            v_ram_we    <= 1'b0;
            v_ram_addr  <= '0;
            v_ram_wdata <= '0;
            err         <= 1'b0;
        end else begin
            p_ram_we <= 1'b0;
            v_ram_we <= 1'b0;
            err      <= 1'b0;
            if (state == FILL && remain != '0) begin
                // Burst continues: data held, address wraps modulo RAM size.
                v_ram_we   <= 1'b1;
                v_ram_addr <= v_ram_addr + 1'b1;
                remain     <= remain - 1'b1;
            end else begin
                state <= IDLE;
                if (pop) begin
                    case (head_mode)
                        MODE_POKE: begin
                            p_ram_we    <= 1'b1;
                            p_ram_addr  <= head_addr;
                            p_ram_wdata <= head_data;
                        end
                        MODE_STORE: begin
                            v_ram_we    <= 1'b1;
                            v_ram_addr  <= head_addr;
                            v_ram_wdata <= head_data;
                        end
                        MODE_FILL: begin
                            // A zero-length fill is silently dropped.
                            if (head_count != '0) begin
                                v_ram_we    <= 1'b1;
                                v_ram_addr  <= head_addr;
                                v_ram_wdata <= head_data;
                                remain      <= head_count - 1'b1;
                                state       <= FILL;
                            end
                        end
                        default: begin
                            err <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_writeback_controller.sv
// Bench for ram_writeback_controller. The reference model turns each accepted
// request into a timeline: the entry leaves the queue at the later of (accept
// edge + 1) and the first edge the sequencer is free, then occupies one slot
// per written word (at least one slot). Expected outputs are per-edge arrays.
module tb_ram_writeback_controller;

    localparam int DEPTH = 4;
    localparam int MAXC  = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_mode = '0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_data = '0;
    logic [7:0]  req_count = '0;
    logic        p_ram_we;
    logic [7:0]  p_ram_addr;
    logic [15:0] p_ram_wdata;
    logic        v_ram_we;
    logic [7:0]  v_ram_addr;
    logic [15:0] v_ram_wdata;
    logic        busy;
    logic        err;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int next_free = 0;

    // Expected state observed just after edge k.
    logic        exp_pwe  [MAXC];
    logic        exp_vwe  [MAXC];
    logic        exp_err  [MAXC];
    logic [7:0]  exp_addr [MAXC];
    logic [15:0] exp_data [MAXC];
    int          exp_occ  [MAXC];

    ram_writeback_controller dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mode    (req_mode),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_count   (req_count),
        .p_ram_we    (p_ram_we),
        .p_ram_addr  (p_ram_addr),
        .p_ram_wdata (p_ram_wdata),
        .v_ram_we    (v_ram_we),
        .v_ram_addr  (v_ram_addr),
        .v_ram_wdata (v_ram_wdata),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int k = 0; k < MAXC; k++) begin
            exp_pwe[k]  = 1'b0;
            exp_vwe[k]  = 1'b0;
            exp_err[k]  = 1'b0;
            exp_addr[k] = '0;
            exp_data[k] = '0;
            exp_occ[k]  = 0;
        end
        next_free = 0;
    endtask

    task automatic schedule(input int e, input logic [2:0] m, input logic [7:0] a,
                            input logic [15:0] d, input logic [7:0] n);
        int p;
        int cost;
        p = (e + 1 > next_free) ? e + 1 : next_free;
        for (int k = e; k < p; k++) exp_occ[k]++;
        cost = 1;
        case (m)
            3'd1: begin exp_pwe[p] = 1'b1; exp_addr[p] = a; exp_data[p] = d; end
            3'd2: begin exp_vwe[p] = 1'b1; exp_addr[p] = a; exp_data[p] = d; end
            3'd3: begin
                if (n != 0) begin
                    cost = int'(n);
                    for (int i = 0; i < int'(n); i++) begin
                        exp_vwe[p + i]  = 1'b1;
                        exp_addr[p + i] = a + 8'(i);
                        exp_data[p + i] = d;
                    end
                end
            end
            default: exp_err[p] = 1'b1;
        endcase
        next_free = p + cost;
    endtask

    function automatic logic [31:0] exp_vec(input int k);
        logic [7:0]  a;
        logic [15:0] d;
        logic        b;
        logic        r;
        a = (exp_pwe[k] || exp_vwe[k]) ? exp_addr[k] : 8'h00;
        d = (exp_pwe[k] || exp_vwe[k]) ? exp_data[k] : 16'h0000;
        b = (exp_occ[k] != 0) || exp_pwe[k] || exp_vwe[k];
        r = (exp_occ[k] < DEPTH);
        return {3'b000, exp_pwe[k], exp_vwe[k], exp_err[k], b, r, a, d};
    endfunction

    function automatic logic [31:0] obs_vec();
        logic [7:0]  a;
        logic [15:0] d;
        a = '0;
        d = '0;
        if (p_ram_we) begin
            a = p_ram_addr;
            d = p_ram_wdata;
        end else if (v_ram_we) begin
            a = v_ram_addr;
            d = v_ram_wdata;
        end
        return {3'b000, p_ram_we, v_ram_we, err, busy, req_ready, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Present a request (or nothing) for the coming edge; the model decides acceptance.
    task automatic drive(input logic v, input logic [2:0] m, input logic [7:0] a,
                         input logic [15:0] d, input logic [7:0] n, output logic acc);
        req_valid = v;
        req_mode  = m;
        req_addr  = a;
        req_data  = d;
        req_count = n;
        acc = v && !rst && (exp_occ[cyc] < DEPTH);
        if (acc) schedule(cyc + 1, m, a, d, n);
    endtask

    task automatic test_reset();
        logic acc;
        model_clear();
        rst = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 16'h0000, 8'h00, acc);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({p_ram_we, v_ram_we, err, busy, req_ready} !== 5'b00001) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%b expected=00001", cyc,
                         {p_ram_we, v_ram_we, err, busy, req_ready});
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec(cyc));
            end
        end
    endtask

    task automatic test_poke();
        logic acc;
        int   accept_edge;
        int   pcount;
        int   vcount;
        pcount = 0;
        vcount = 0;
        drive(1'b1, 3'd1, 8'h10, 16'hBEEF, 8'h00, acc);
        accept_edge = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            drive(1'b0, 3'd0, 8'h00, 16'h0000, 8'h00, acc);
            if (p_ram_we === 1'b1) pcount++;
            if (v_ram_we === 1'b1) vcount++;
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL poke cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec(cyc));
            end
            if (cyc == accept_edge + 1) begin
                checks++;
                if ({p_ram_we, p_ram_addr, p_ram_wdata} !== {1'b1, 8'h10, 16'hBEEF}) begin
                    failures++;
                    $display("FAIL poke_latency got=%h expected=%h",
                             {p_ram_we, p_ram_addr, p_ram_wdata}, {1'b1, 8'h10, 16'hBEEF});
                end
            end
        end
        checks++;
        if (pcount != 1 || vcount != 0) begin
            failures++;
            $display("FAIL poke_width got p=%0d v=%0d expected p=1 v=0", pcount, vcount);
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        drive(1'b1, 3'd3, 8'h40, 16'h5555, 8'd8, acc);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd2, 8'(i), 16'hC000 + 16'(i), 8'h00, acc);
            tick();
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL b2b_push cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec(cyc));
            end
        end
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full_ready got=%b expected=0", req_ready);
        end
        drive(1'b0, 3'd0, 8'h00, 16'h0000, 8'h00, acc);
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL b2b_drain cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec(cyc));
            end
        end
    endtask

    task automatic test_fill_wrap();
        logic       acc;
        logic [7:0] seen[$];
        logic [7:0] want[5];
        want = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h77};
        drive(1'b1, 3'd3, 8'hFE, 16'h1234, 8'd4, acc);
        tick();
        drive(1'b1, 3'd2, 8'h77, 16'hABCD, 8'h00, acc);
        for (int i = 0; i < 9; i++) begin
            if (v_ram_we === 1'b1) seen.push_back(v_ram_addr);
            tick();
            if (i == 0) drive(1'b0, 3'd0, 8'h00, 16'h0000, 8'h00, acc);
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL fill_wrap cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec(cyc));
            end
        end
        if (v_ram_we === 1'b1) seen.push_back(v_ram_addr);
        checks++;
        if (seen.size() != 5) begin
            failures++;
            $display("FAIL fill_wrap_count got=%0d expected=5", seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (seen[i] !== want[i]) begin
                    failures++;
                    $display("FAIL fill_wrap_addr idx=%0d got=%h expected=%h", i, seen[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_err();
        logic acc;
        int   errs;
        int   writes;
        errs   = 0;
        writes = 0;
        drive(1'b1, 3'd3, 8'h20, 16'h9999, 8'd0, acc);
        tick();
        drive(1'b1, 3'd5, 8'h21, 16'h8888, 8'd3, acc);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) drive(1'b0, 3'd0, 8'h00, 16'h0000, 8'h00, acc);
            if (err === 1'b1) errs++;
            if (p_ram_we === 1'b1 || v_ram_we === 1'b1) writes++;
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL err_mode cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec(cyc));
            end
        end
        checks++;
        if (errs != 1 || writes != 0) begin
            failures++;
            $display("FAIL err_pulse got err=%0d writes=%0d expected err=1 writes=0", errs, writes);
        end
    endtask

    task automatic test_full();
        logic acc;
        int   waited;
        waited = 0;
        drive(1'b1, 3'd3, 8'h00, 16'h1111, 8'd6, acc);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd2, 8'hA0 + 8'(i), 16'(i * 16'h0101), 8'h00, acc);
            tick();
        end
        acc = 1'b0;
        for (int i = 0; i < 12 && !acc; i++) begin
            drive(1'b1, 3'd1, 8'hB5, 16'h5A5A, 8'h00, acc);
            if (!acc) waited++;
            tick();
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL full_hold cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec(cyc));
            end
        end
        checks++;
        if (!acc || waited != 3) begin
            failures++;
            $display("FAIL full_accept got acc=%0d waited=%0d expected acc=1 waited=3", acc, waited);
        end
        drive(1'b0, 3'd0, 8'h00, 16'h0000, 8'h00, acc);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL full_drain cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec(cyc));
            end
        end
    endtask

    task automatic test_async_reset();
        logic acc;
        int   writes;
        writes = 0;
        drive(1'b1, 3'd3, 8'h80, 16'h0F0F, 8'd5, acc);
        tick();
        drive(1'b1, 3'd2, 8'h31, 16'h3131, 8'h00, acc);
        tick();
        drive(1'b1, 3'd1, 8'h32, 16'h3232, 8'h00, acc);
        tick();
        checks++;
        if (obs_vec() !== exp_vec(cyc)) begin
            failures++;
            $display("FAIL areset_pre cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec(cyc));
        end
        drive(1'b0, 3'd0, 8'h00, 16'h0000, 8'h00, acc);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        checks++;
        if ({p_ram_we, v_ram_we, err, busy, req_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL areset_immediate got=%b expected=00001",
                     {p_ram_we, v_ram_we, err, busy, req_ready});
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (p_ram_we !== 1'b0 || v_ram_we !== 1'b0) writes++;
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL areset_after cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec(cyc));
            end
        end
        checks++;
        if (writes != 0) begin
            failures++;
            $display("FAIL areset_no_writes got=%0d expected=0", writes);
        end
    endtask

    task automatic test_random();
        logic       acc;
        logic       v;
        logic [2:0] m;
        int         r;
        for (int i = 0; i < 300; i++) begin
            v = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 3)       m = 3'd1;
            else if (r < 6)  m = 3'd2;
            else if (r < 8)  m = 3'd3;
            else if (r == 8) m = 3'd0;
            else             m = 3'($urandom_range(4, 7));
            drive(v, m, 8'($urandom), 16'($urandom), 8'($urandom_range(0, 5)), acc);
            tick();
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec(cyc));
            end
        end
        drive(1'b0, 3'd0, 8'h00, 16'h0000, 8'h00, acc);
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL random_drain cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec(cyc));
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_poke();
        test_back_to_back();
        test_fill_wrap();
        test_err();
        test_full();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
